// File: rtl/mem_access_unit_if.sv
// Core/bus signal bundle for mem_access_unit: operand latches, access control and word bus.
// The slave modport is the unit itself; master is the core plus memory side.
interface mem_access_unit_if #(
   parameter int unsigned BUS_BYTES = 2,
   parameter int unsigned ADDR_W    = 20
);
   localparam int unsigned OFF_W = $clog2(BUS_BYTES);
   localparam int unsigned WA_W  = ADDR_W - OFF_W;
   localparam int unsigned DW    = 8 * BUS_BYTES;

   logic                 write_mar;
   logic [15:0]          mar_in;
   logic [15:0]          mar_out;
   logic [15:0]          segment;
   logic                 write_mdr;
   logic [31:0]          mdr_in;
   logic [31:0]          mdr_out;
   logic                 start;
   logic                 io;
   logic                 wr_en;
   logic [1:0]           size;
   logic                 busy;
   logic                 complete;
   logic [WA_W-1:0]      m_addr;
   logic [DW-1:0]        m_data_out;
   logic [DW-1:0]        m_data_in;
   logic                 m_access;
   logic                 m_ack;
   logic                 m_wr_en;
   logic [BUS_BYTES-1:0] m_bytesel;

   modport slave (
      input  write_mar, mar_in, segment, write_mdr, mdr_in, start, io, wr_en, size,
             m_data_in, m_ack,
      output mar_out, mdr_out, busy, complete, m_addr, m_data_out, m_access, m_wr_en, m_bytesel
   );

   modport master (
      output write_mar, mar_in, segment, write_mdr, mdr_in, start, io, wr_en, size,
             m_data_in, m_ack,
      input  mar_out, mdr_out, busy, complete, m_addr, m_data_out, m_access, m_wr_en, m_bytesel
   );
endinterface

// File: rtl/mem_access_unit.sv
// Segmented load/store engine: moves an 8/16/32-bit operand over a BUS_BYTES-wide bus in 1..3 beats.
// Optional MAR_AUTOINC_EN: mar advances by the operand size on the complete cycle.
module mem_access_unit #(
   parameter int unsigned BUS_BYTES = 2,
   parameter int unsigned ADDR_W    = 20,
   parameter int unsigned SEG_SHIFT = 4
) (
   input logic              clk,
   input logic              reset,
   mem_access_unit_if.slave bus
);
   localparam int unsigned OFF_W = $clog2(BUS_BYTES);
   localparam int unsigned WA_W  = ADDR_W - OFF_W;
   localparam int unsigned DW    = 8 * BUS_BYTES;

   typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_GAP, ST_DONE} state_e;

   state_e              state_q, state_d;
   logic [15:0]         mar_q, mar_d;
   logic [31:0]         mdr_q, mdr_d;
   logic [ADDR_W-1:0]   lin_q, lin_d;
   logic                wr_q, wr_d;
   logic [2:0]          nbytes_q, nbytes_d;
   logic [1:0]          beat_q, beat_d;
   logic [1:0]          last_q, last_d;
   logic                complete_q, complete_d;

   logic [2:0]          nbytes_c;
   logic [ADDR_W-1:0]   seg_base_c, lin_c;
   logic [3:0]          span_c;
   logic [1:0]          last_c;
   logic [OFF_W-1:0]    cur_off_c;
   logic [BUS_BYTES-1:0] sel_c;
   logic [DW-1:0]       wdata_c;
   logic [31:0]         mdr_rd_c;

   // Address and beat count of a new access, formed from the inputs present at start
   always_comb begin
      case (bus.size)
         2'd0:    nbytes_c = 3'd1;
         2'd1:    nbytes_c = 3'd2;
         default: nbytes_c = 3'd4;
      endcase
      seg_base_c = ADDR_W'(bus.segment) << SEG_SHIFT;
      lin_c      = bus.io ? ADDR_W'(mar_q) : seg_base_c + ADDR_W'(mar_q);
      span_c     = 4'(lin_c[OFF_W-1:0]) + 4'(nbytes_c);
      last_c     = 2'((span_c - 4'd1) >> OFF_W);
   end

   assign cur_off_c = lin_q[OFF_W-1:0];

   // Lane <-> operand byte mapping for the current beat
   always_comb begin
      sel_c    = '0;
      wdata_c  = '0;
      mdr_rd_c = mdr_q;
      if (state_q == ST_BUS) begin
         for (int l = 0; l < int'(BUS_BYTES); l++) begin
            for (int i = 0; i < 4; i++) begin
               if (i < int'(nbytes_q) &&
                   int'(beat_q) * int'(BUS_BYTES) + l == int'(cur_off_c) + i) begin
                  sel_c[l]           = 1'b1;
                  wdata_c[8*l +: 8]  = mdr_q[8*i +: 8];
                  mdr_rd_c[8*i +: 8] = bus.m_data_in[8*l +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      lin_d      = lin_q;
      wr_d       = wr_q;
      nbytes_d   = nbytes_q;
      beat_d     = beat_q;
      last_d     = last_q;
      mdr_d      = mdr_q;
      complete_d = (state_q == ST_DONE);

      mar_d = mar_q;
      if (bus.write_mar) begin
         mar_d = bus.mar_in;
      end
`ifdef MAR_AUTOINC_EN
      else if (complete_q) begin
         mar_d = mar_q + 16'(nbytes_q);
      end
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d  = ST_BUS;
               lin_d    = lin_c;
               wr_d     = bus.wr_en;
               nbytes_d = nbytes_c;
               last_d   = last_c;
               beat_d   = 2'd0;
            end
            if (bus.start && !bus.wr_en) begin
               mdr_d = '0;
            end else if (bus.write_mdr) begin
               mdr_d = bus.mdr_in;
            end
         end
         ST_BUS: begin
            if (bus.m_ack) begin
               if (!wr_q) begin
                  mdr_d = mdr_rd_c;
               end
               if (beat_q != last_q) begin
                  beat_d  = beat_q + 2'd1;
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_GAP:  state_d = ST_BUS;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mar_q      <= '0;
         mdr_q      <= '0;
         lin_q      <= '0;
         wr_q       <= 1'b0;
         nbytes_q   <= 3'd0;
         beat_q     <= 2'd0;
         last_q     <= 2'd0;
         complete_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mar_q      <= mar_d;
         mdr_q      <= mdr_d;
         lin_q      <= lin_d;
         wr_q       <= wr_d;
         nbytes_q   <= nbytes_d;
         beat_q     <= beat_d;
         last_q     <= last_d;
         complete_q <= complete_d;
      end
   end

   assign bus.mar_out    = mar_q;
   assign bus.mdr_out    = mdr_q;
   assign bus.busy       = (bus.start && state_q == ST_IDLE) || (state_q != ST_IDLE);
   assign bus.complete   = complete_q;
   assign bus.m_access   = (state_q == ST_BUS);
   assign bus.m_wr_en    = wr_q;
   assign bus.m_addr     = WA_W'(lin_q[ADDR_W-1:OFF_W]) + WA_W'(beat_q);
   assign bus.m_bytesel  = sel_c;
   assign bus.m_data_out = wdata_c;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 2-byte bus instance with directed and random accesses against a
// byte-image model, plus a 4-byte bus instance for lane placement.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_access_unit_if #(.BUS_BYTES(2), .ADDR_W(20)) bus2 ();
   mem_access_unit_if #(.BUS_BYTES(4), .ADDR_W(20)) bus4 ();

   mem_access_unit #(.BUS_BYTES(2), .ADDR_W(20), .SEG_SHIFT(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
   mem_access_unit #(.BUS_BYTES(4), .ADDR_W(20), .SEG_SHIFT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic init_inputs();
      bus2.write_mar = 0; bus2.mar_in = '0; bus2.segment = '0; bus2.write_mdr = 0; bus2.mdr_in = '0;
      bus2.start = 0; bus2.io = 0; bus2.wr_en = 0; bus2.size = '0; bus2.m_data_in = '0; bus2.m_ack = 0;
      bus4.write_mar = 0; bus4.mar_in = '0; bus4.segment = '0; bus4.write_mdr = 0; bus4.mdr_in = '0;
      bus4.start = 0; bus4.io = 0; bus4.wr_en = 0; bus4.size = '0; bus4.m_data_in = '0; bus4.m_ack = 0;
   endtask

   // Noise on inputs that must be ignored while an access is in flight
   task automatic jiggle();
      bus2.start     = 1'($urandom_range(0, 1));
      bus2.write_mdr = 1'($urandom_range(0, 1));
      bus2.mdr_in    = $urandom;
      bus2.io        = 1'($urandom_range(0, 1));
      bus2.wr_en     = 1'($urandom_range(0, 1));
      bus2.size      = 2'($urandom_range(0, 3));
      bus2.segment   = 16'($urandom);
   endtask

   task automatic quiet();
      bus2.start = 0;
      bus2.write_mdr = 0;
   endtask

   task automatic test_reset();
      init_inputs();
      reset = 1;
      repeat (3) @(negedge clk);
      reset = 0;
      @(negedge clk);
      n_cmp++; if (bus2.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", bus2.busy); end
      n_cmp++; if (bus2.complete !== 1'b0) begin n_err++; $display("FAIL reset complete: got %b want 0", bus2.complete); end
      n_cmp++; if (bus2.m_access !== 1'b0) begin n_err++; $display("FAIL reset m_access: got %b want 0", bus2.m_access); end
      n_cmp++; if (bus2.m_bytesel !== 2'b00) begin n_err++; $display("FAIL reset bytesel: got %b want 00", bus2.m_bytesel); end
      n_cmp++; if (bus2.m_wr_en !== 1'b0) begin n_err++; $display("FAIL reset m_wr_en: got %b want 0", bus2.m_wr_en); end
      n_cmp++; if (bus2.mar_out !== 16'h0) begin n_err++; $display("FAIL reset mar: got %h want 0", bus2.mar_out); end
      n_cmp++; if (bus2.mdr_out !== 32'h0) begin n_err++; $display("FAIL reset mdr: got %h want 0", bus2.mdr_out); end
      n_cmp++; if (bus4.m_access !== 1'b0 || bus4.m_bytesel !== 4'h0) begin n_err++; $display("FAIL reset bus4: got acc %b sel %b want 0/0000", bus4.m_access, bus4.m_bytesel); end
   endtask

   // One full access on the 2-byte bus; abort_beat >= 0 asserts reset while that beat is requested
   task automatic run_access(input bit io_v, input bit wr_v, input logic [1:0] sz,
                             input logic [15:0] seg, input logic [15:0] mar, input logic [31:0] wdata,
                             input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
                             input int abort_beat, input string tag);
      logic [15:0] rd [3];
      logic [7:0]  img [8];
      bit          sel [8];
      int unsigned lin;
      int          off, nb, beats, pos, dly;
      logic [31:0] exp_mdr;
      logic [15:0] exp_mar, exp_dat;
      logic [18:0] exp_addr;
      logic [1:0]  exp_sel;

      rd[0] = r0; rd[1] = r1; rd[2] = r2;
      lin   = io_v ? 32'(mar) : (((32'(seg) << 4) + 32'(mar)) & 32'h000F_FFFF);
      off   = int'(lin % 2);
      nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      beats = (off + nb + 1) / 2;
      for (int p = 0; p < 8; p++) begin img[p] = 8'h00; sel[p] = 0; end
      exp_mdr = wr_v ? wdata : 32'h0;
      for (int i = 0; i < nb; i++) begin
         pos      = off + i;
         sel[pos] = 1;
         img[pos] = 8'(wdata >> (8 * i));
         if (!wr_v) exp_mdr = exp_mdr | (32'(8'(rd[pos / 2] >> (8 * (pos % 2)))) << (8 * i));
      end
`ifdef MAR_AUTOINC_EN
      exp_mar = 16'(int'(mar) + nb);
`else
      exp_mar = mar;
`endif

      @(negedge clk);
      bus2.write_mar = 1; bus2.mar_in = mar; bus2.write_mdr = 1; bus2.mdr_in = wdata;
      @(negedge clk);
      bus2.write_mar = 0; bus2.write_mdr = 0;
      n_cmp++; if (bus2.mar_out !== mar) begin n_err++; $display("FAIL %s mar load: got %h want %h", tag, bus2.mar_out, mar); end
      n_cmp++; if (bus2.mdr_out !== wdata) begin n_err++; $display("FAIL %s mdr load: got %h want %h", tag, bus2.mdr_out, wdata); end
      bus2.start = 1; bus2.io = io_v; bus2.wr_en = wr_v; bus2.size = sz; bus2.segment = seg;
      #1;
      n_cmp++; if (bus2.busy !== 1'b1) begin n_err++; $display("FAIL %s busy on start: got %b want 1", tag, bus2.busy); end

      for (int b = 0; b < beats; b++) begin
         exp_addr = 19'((lin >> 1) + 32'(b));
         exp_sel  = {sel[2*b+1], sel[2*b]};
         exp_dat  = {img[2*b+1], img[2*b]};
         @(negedge clk);
         n_cmp++; if (bus2.m_access !== 1'b1) begin n_err++; $display("FAIL %s m_access beat %0d: got %b want 1", tag, b, bus2.m_access); end
         n_cmp++; if (bus2.m_addr !== exp_addr) begin n_err++; $display("FAIL %s m_addr beat %0d: got %h want %h", tag, b, bus2.m_addr, exp_addr); end
         n_cmp++; if (bus2.m_bytesel !== exp_sel) begin n_err++; $display("FAIL %s bytesel beat %0d: got %b want %b", tag, b, bus2.m_bytesel, exp_sel); end
         n_cmp++; if (bus2.m_wr_en !== wr_v) begin n_err++; $display("FAIL %s m_wr_en beat %0d: got %b want %b", tag, b, bus2.m_wr_en, wr_v); end
         n_cmp++; if (bus2.busy !== 1'b1) begin n_err++; $display("FAIL %s busy beat %0d: got %b want 1", tag, b, bus2.busy); end
         if (wr_v) begin
            n_cmp++; if (bus2.m_data_out !== exp_dat) begin n_err++; $display("FAIL %s wdata beat %0d: got %h want %h", tag, b, bus2.m_data_out, exp_dat); end
         end
         if (b == abort_beat) begin
            quiet();
            reset = 1;
            @(negedge clk);
            reset = 0;
            n_cmp++; if (bus2.m_access !== 1'b0) begin n_err++; $display("FAIL %s abort m_access: got %b want 0", tag, bus2.m_access); end
            n_cmp++; if (bus2.busy !== 1'b0) begin n_err++; $display("FAIL %s abort busy: got %b want 0", tag, bus2.busy); end
            n_cmp++; if (bus2.mar_out !== 16'h0) begin n_err++; $display("FAIL %s abort mar: got %h want 0", tag, bus2.mar_out); end
            n_cmp++; if (bus2.mdr_out !== 32'h0) begin n_err++; $display("FAIL %s abort mdr: got %h want 0", tag, bus2.mdr_out); end
            n_cmp++; if (bus2.m_bytesel !== 2'b00 || bus2.complete !== 1'b0) begin n_err++; $display("FAIL %s abort sel/complete: got %b/%b want 00/0", tag, bus2.m_bytesel, bus2.complete); end
            return;
         end
         jiggle();
         dly = $urandom_range(0, 2);
         repeat (dly) begin
            @(negedge clk);
            n_cmp++; if (bus2.m_access !== 1'b1 || bus2.m_addr !== exp_addr) begin n_err++; $display("FAIL %s hold beat %0d: got acc %b addr %h want 1/%h", tag, b, bus2.m_access, bus2.m_addr, exp_addr); end
            jiggle();
         end
         bus2.m_ack = 1; bus2.m_data_in = rd[b];
         @(negedge clk);
         bus2.m_ack = 0; bus2.m_data_in = 16'($urandom);
         n_cmp++; if (bus2.m_access !== 1'b0) begin n_err++; $display("FAIL %s gap after beat %0d: m_access got %b want 0", tag, b, bus2.m_access); end
         n_cmp++; if (bus2.busy !== 1'b1 || bus2.complete !== 1'b0) begin n_err++; $display("FAIL %s after beat %0d busy/complete: got %b/%b want 1/0", tag, b, bus2.busy, bus2.complete); end
         if (b == beats - 1) quiet(); else jiggle();
      end

      @(negedge clk);
      n_cmp++; if (bus2.complete !== 1'b1) begin n_err++; $display("FAIL %s complete: got %b want 1", tag, bus2.complete); end
      n_cmp++; if (bus2.busy !== 1'b0) begin n_err++; $display("FAIL %s busy in complete: got %b want 0", tag, bus2.busy); end
      n_cmp++; if (bus2.mdr_out !== exp_mdr) begin n_err++; $display("FAIL %s mdr result: got %h want %h", tag, bus2.mdr_out, exp_mdr); end
      n_cmp++; if (bus2.mar_out !== mar) begin n_err++; $display("FAIL %s mar in complete: got %h want %h", tag, bus2.mar_out, mar); end
      @(negedge clk);
      n_cmp++; if (bus2.complete !== 1'b0) begin n_err++; $display("FAIL %s complete width: got %b want 0", tag, bus2.complete); end
      n_cmp++; if (bus2.mar_out !== exp_mar) begin n_err++; $display("FAIL %s mar after: got %h want %h", tag, bus2.mar_out, exp_mar); end
   endtask

   task automatic test_directed();
      run_access(1, 0, 2'd1, 16'h0000, 16'h0010, 32'h0, 16'hBEEF, 16'h0, 16'h0, -1, "io_read16");
      run_access(0, 0, 2'd1, 16'h1000, 16'h0003, 32'h0, 16'h12AB, 16'h34CD, 16'h0, -1, "seg_read16_split");
      run_access(1, 1, 2'd2, 16'h0000, 16'h0001, 32'h44332211, 16'h0, 16'h0, 16'h0, -1, "io_write32_3beat");
      run_access(0, 0, 2'd3, 16'hFFFF, 16'h000F, 32'h0, 16'h5A00, 16'hC3B2, 16'h00E1, -1, "addr_wrap_read32");
      run_access(0, 1, 2'd0, 16'h0123, 16'h4567, 32'hDEADBE77, 16'h0, 16'h0, 16'h0, -1, "seg_write8");
   endtask

   task automatic test_reset_midaccess();
      run_access(1, 1, 2'd2, 16'h0000, 16'h0001, 32'h44332211, 16'h0, 16'h0, 16'h0, 2, "abort_write32");
      run_access(1, 0, 2'd2, 16'h0000, 16'h0002, 32'h0, 16'h2211, 16'h4433, 16'h0, -1, "after_abort_read32");
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    16'($urandom), 16'($urandom), $urandom,
                    16'($urandom), 16'($urandom), 16'($urandom), -1, "random");
      end
   endtask

   task automatic test_autoinc();
      run_access(1, 0, 2'd2, 16'h0000, 16'hFFFE, 32'h0, 16'h1357, 16'h2468, 16'h0, -1, "mar_wrap_read32");
   endtask

   task automatic test_bus4();
      @(negedge clk);
      bus4.write_mar = 1; bus4.mar_in = 16'h0003;
      @(negedge clk);
      bus4.write_mar = 0; bus4.start = 1; bus4.io = 1; bus4.wr_en = 0; bus4.size = 2'd0;
      @(negedge clk);
      bus4.start = 0;
      n_cmp++; if (bus4.m_access !== 1'b1) begin n_err++; $display("FAIL bus4 read8 m_access: got %b want 1", bus4.m_access); end
      n_cmp++; if (bus4.m_bytesel !== 4'b1000) begin n_err++; $display("FAIL bus4 read8 bytesel: got %b want 1000", bus4.m_bytesel); end
      n_cmp++; if (bus4.m_addr !== 18'h0) begin n_err++; $display("FAIL bus4 read8 m_addr: got %h want 0", bus4.m_addr); end
      bus4.m_ack = 1; bus4.m_data_in = 32'hA500_0000;
      @(negedge clk);
      bus4.m_ack = 0; bus4.m_data_in = '0;
      @(negedge clk);
      n_cmp++; if (bus4.complete !== 1'b1) begin n_err++; $display("FAIL bus4 read8 complete: got %b want 1", bus4.complete); end
      n_cmp++; if (bus4.mdr_out !== 32'h0000_00A5) begin n_err++; $display("FAIL bus4 read8 mdr: got %h want 000000a5", bus4.mdr_out); end
      bus4.write_mar = 1; bus4.mar_in = 16'h0004; bus4.write_mdr = 1; bus4.mdr_in = 32'h89AB_CDEF;
      @(negedge clk);
      bus4.write_mar = 0; bus4.write_mdr = 0; bus4.start = 1; bus4.wr_en = 1; bus4.size = 2'd2;
      @(negedge clk);
      bus4.start = 0;
      n_cmp++; if (bus4.m_bytesel !== 4'b1111 || bus4.m_addr !== 18'h1) begin n_err++; $display("FAIL bus4 write32 sel/addr: got %b/%h want 1111/1", bus4.m_bytesel, bus4.m_addr); end
      n_cmp++; if (bus4.m_data_out !== 32'h89AB_CDEF) begin n_err++; $display("FAIL bus4 write32 data: got %h want 89abcdef", bus4.m_data_out); end
      bus4.m_ack = 1;
      @(negedge clk);
      bus4.m_ack = 0;
      @(negedge clk);
      n_cmp++; if (bus4.complete !== 1'b1 || bus4.busy !== 1'b0) begin n_err++; $display("FAIL bus4 write32 complete/busy: got %b/%b want 1/0", bus4.complete, bus4.busy); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_midaccess();
      test_autoinc();
      test_bus4();
      test_random();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store engine between the execution core and the memory/IO bus.
- Latches a 16-bit offset and a segment, and forms a segmented linear address (or an unsegmented IO address).
- Moves an 8/16/32-bit operand over a BUS_BYTES-wide bus, splitting unaligned operands into as many bus beats as needed.
- Successor to the 16-bit, two-beat load/store: bus width and operand size are generalised, and multi-beat assembly is arbitrary.

Parameters:
- BUS_BYTES, 2, bus width in bytes; legal values 2 or 4.
- ADDR_W, 20, linear byte-address width; the bus carries bits ADDR_W-1 down to log2(BUS_BYTES).
- SEG_SHIFT, 4, left shift applied to segment before adding the offset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- write_mar  in  1  load mar from mar_in.
- mar_in  in  16  offset.
- mar_out  out  16  current mar.
- segment  in  16  segment; used only when io=0.
- write_mdr  in  1  load mdr from mdr_in.
- mdr_in  in  32  write data.
- mdr_out  out  32  current mdr.
- start  in  1  begin an access; honoured only while idle.
- io  in  1  1 = IO space, no segment added.
- wr_en  in  1  1 = write, 0 = read; sampled at start.
- size  in  2  0 = 8-bit, 1 = 16-bit, 2 or 3 = 32-bit; sampled at start.
- busy  out  1  access in progress.
- complete  out  1  one-cycle done pulse.
- m_addr  out  ADDR_W-log2(BUS_BYTES)  bus word address.
- m_data_out  out  8*BUS_BYTES  write data.
- m_data_in  in  8*BUS_BYTES  read data; valid with m_ack.
- m_access  out  1  bus request.
- m_ack  in  1  one-cycle acknowledge.
- m_wr_en  out  1  latched wr_en.
- m_bytesel  out  BUS_BYTES  byte-lane enables.

Behaviour:
- Reset values: mar=0, mdr=0, state IDLE, beat=0. Outputs: busy=0, complete=0, m_access=0, m_bytesel=0, m_wr_en=0.
- Linear address: lin = io ? zero-extended mar : ((segment<<SEG_SHIFT) + mar) mod 2^ADDR_W.
  - off = lin mod BUS_BYTES.
  - nbytes = 1, 2 or 4 from size.
  - beats = ceil((off+nbytes)/BUS_BYTES); range 1..3.
- m_addr = (lin/BUS_BYTES + beat) mod 2^(ADDR_W-log2 BUS_BYTES); wraps silently.
- FSM states:
  - IDLE: start=1 goes to BUS. On that edge, latch wr_en/size/io/segment, clear beat, and clear mdr if read.
  - BUS: m_access=1 until m_ack is sampled. On m_ack: if beat<beats-1, beat+=1 and stay in BUS, with m_access low for exactly one cycle before the next beat; else go to DONE.
  - DONE: complete=1 for one cycle, then go to IDLE.
- busy = (start while IDLE) | state!=IDLE, and is 0 in the complete cycle.
- start while busy is ignored. mar/mdr/segment changes during an access are ignored: address fields are latched at start and mar writes take effect at the next access.
- Byte mapping: operand byte i uses lane (off+i) mod BUS_BYTES in beat floor((off+i)/BUS_BYTES).
  - Read: on m_ack, the lanes of that beat are written into the matching mdr bytes.
  - Bytes i ≥ nbytes are zero (zero-extend).
  - mdr is final on the complete cycle.
- Write: m_data_out places mdr bytes on their lanes for the current beat; unused lanes are 0. m_bytesel flags exactly the lanes used in the current beat.
- write_mdr in the same cycle as a read m_ack: the m_ack data wins.
- reset mid-access: immediate return to reset values; the outstanding bus cycle is abandoned.

Optional Feature:
- Macro: MAR_AUTOINC_EN.
- Defined: on the complete cycle, mar += nbytes (16-bit wrap) unless write_mar is asserted in the same cycle, in which case write_mar wins. Supports string operations.
- Not defined: mar changes only through write_mar.

Test Plan:
1. BUS_BYTES=2, io=1, mar=0x0010, 16-bit read, m_data_in=0xBEEF -> one beat, m_addr=0x0008, bytesel=11, mdr=0x0000BEEF, complete pulses two cycles after m_ack; busy low in complete cycle.
2. BUS_BYTES=2, segment=0x1000, mar=0x0003, 16-bit read, beats return 0x12AB then 0x34CD -> m_addr 0x08001 then 0x08002, bytesel 10 then 01, mdr=0x0000CD12.
3. BUS_BYTES=2, io=1, mar=0x0001, 32-bit write, mdr=0x44332211 -> three beats: data 0x1100/bytesel 10, 0x3322/11, 0x0044/01.
4. BUS_BYTES=4, io=1, mar=0x0003, 8-bit read, m_data_in=0xA5000000 -> one beat, bytesel=1000, mdr=0x000000A5.
5. Reset asserted during beat 2 of case 3 -> next cycle m_access=0, busy=0, mar=0, mdr=0; a new start then runs normally. start during busy -> ignored.
6. MAR_AUTOINC_EN defined, mar=0xFFFE, 32-bit read -> mar=0x0002 after complete; without the macro, mar remains 0xFFFE.
